fe_mul_arbiter: RTL and testbench

- Shares one fe_mulx field multiplier among NREQ independent requesters, such as the point-add, point-double and inversion sequencers.
- Grants are issued round-robin.
- Operands are registered and presented to the multiplier; the product is returned on a shared result bus with a per-requester done pulse.
- Sits between the group-element sequencers and the single fe_mulx instance.

---
 rtl/fe_mul_arbiter_pkg.sv | 35 +++
 rtl/fe_rr_pick.sv | 31 +++
 rtl/fe_mul_arbiter.sv | 135 +++++++++++++
 tb/tb_fe_mul_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_mul_arbiter_pkg.sv
// Shared definitions for the field-multiplier arbiter: default element width,
// arbiter state encoding and width helpers.
package fe_mul_arbiter_pkg;

   // Default field-element width: 10 limbs of 32 bits.
   localparam int unsigned FE_WIDTH = 320;

   // Arbiter states; encodings are fixed so they can be probed from outside.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

   // Width of a requester index; at least one bit so a single requester
   // still gets a legal vector.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fe_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around NREQ.
module fe_rr_pick
   import fe_mul_arbiter_pkg::*;
#(
   parameter  int unsigned NREQ = 3,
   localparam int unsigned GW   = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   ptr,
   output logic [GW-1:0]   gnt_id,
   output logic            any
);

   logic [GW-1:0] cand;

   // Scan from ptr upward, keep the first hit.
   always_comb begin
      gnt_id = '0;
      any    = 1'b0;
      cand   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = GW'((32'(ptr) + k) % NREQ);
         if (!any && req[cand]) begin
            any    = 1'b1;
            gnt_id = cand;
         end
      end
   end

endmodule

// File: rtl/fe_mul_arbiter.sv
// Shares one fe_mulx field multiplier among NREQ requesters. One transaction
// in flight: IDLE -> ISSUE -> WAIT -> RESP, with round-robin grant selection.
module fe_mul_arbiter
   import fe_mul_arbiter_pkg::*;
#(
   parameter  int unsigned NREQ  = 3,
   parameter  int unsigned FE_W  = FE_WIDTH,
   parameter  int unsigned CNT_W = 32,
   localparam int unsigned GW    = id_width(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*FE_W-1:0] req_op_a,
   input  logic [NREQ*FE_W-1:0] req_op_b,
   output logic [NREQ-1:0]      req_done,
   output logic [FE_W-1:0]      req_res,
   output logic [FE_W-1:0]      mul_op_a,
   output logic [FE_W-1:0]      mul_op_b,
   output logic                 mul_valid,
   input  logic [FE_W-1:0]      mul_res,
   input  logic                 mul_done,
   output logic                 busy,
   output logic [GW-1:0]        grant_id,
   output logic [CNT_W-1:0]     mul_count,
   output logic                 err_stray
);

   arb_state_t       state_q, state_d;
   logic [FE_W-1:0]  op_a_q, op_a_d;
   logic [FE_W-1:0]  op_b_q, op_b_d;
   logic [FE_W-1:0]  res_q, res_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [GW-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [GW-1:0]    pick_id;
   logic             pick_any;

   fe_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req    (req_valid),
      .ptr    (ptr_q),
      .gnt_id (pick_id),
      .any    (pick_any)
   );

   // Next-state, operand capture, counters and error flag.
   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      res_d   = res_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               // Constant-base slices keep the operand mux free of
               // variable-width index arithmetic.
               for (int unsigned i = 0; i < NREQ; i++) begin
                  if (GW'(i) == pick_id) begin
                     op_a_d = req_op_a[i*FE_W +: FE_W];
                     op_b_d = req_op_b[i*FE_W +: FE_W];
                  end
               end
               grant_d = pick_id;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mul_done) begin
               res_d   = mul_res;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            ptr_d   = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (mul_done && (state_q != ST_WAIT)) begin
         err_d = 1'b1;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         res_q   <= res_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      mul_valid = (state_q == ST_ISSUE);
      busy      = (state_q != ST_IDLE);
      req_done  = (state_q == ST_RESP) ? (NREQ'(1) << grant_q) : '0;
   end

   assign mul_op_a  = op_a_q;
   assign mul_op_b  = op_b_q;
   assign req_res   = res_q;
   assign grant_id  = grant_q;
   assign mul_count = cnt_q;
   assign err_stray = err_q;

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Self-checking bench for fe_mul_arbiter with a behavioural multiplier model
// and a queue of expected (requester, product) completions.
module tb_fe_mul_arbiter;

   localparam int unsigned NREQ  = 3;
   localparam int unsigned FE_W  = 320;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned GW    = 2;
   localparam int unsigned LAT   = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ*FE_W-1:0] req_op_a = '0;
   logic [NREQ*FE_W-1:0] req_op_b = '0;
   logic [NREQ-1:0]      req_done;
   logic [FE_W-1:0]      req_res;
   logic [FE_W-1:0]      mul_op_a;
   logic [FE_W-1:0]      mul_op_b;
   logic                 mul_valid;
   logic [FE_W-1:0]      mul_res;
   logic                 mul_done;
   logic                 busy;
   logic [GW-1:0]        grant_id;
   logic [CNT_W-1:0]     mul_count;
   logic                 err_stray;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int unsigned     id;
      logic [FE_W-1:0] res;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;

   fe_mul_arbiter #(
      .NREQ  (NREQ),
      .FE_W  (FE_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_op_a  (req_op_a),
      .req_op_b  (req_op_b),
      .req_done  (req_done),
      .req_res   (req_res),
      .mul_op_a  (mul_op_a),
      .mul_op_b  (mul_op_b),
      .mul_valid (mul_valid),
      .mul_res   (mul_res),
      .mul_done  (mul_done),
      .busy      (busy),
      .grant_id  (grant_id),
      .mul_count (mul_count),
      .err_stray (err_stray)
   );

   // Behavioural multiplier: fixed latency after mul_valid, plus an
   // injectable stray done pulse.
   logic [FE_W-1:0] m_prod;
   int unsigned     m_cnt;
   logic            stray_go = 1'b0;

   always @(posedge clk) begin
      if (!rst) begin
         m_cnt    <= 0;
         mul_done <= 1'b0;
         mul_res  <= '0;
         m_prod   <= '0;
      end else begin
         mul_done <= 1'b0;
         if (stray_go) begin
            mul_done <= 1'b1;
            mul_res  <= FE_W'(32'hdead);
         end
         if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               mul_done <= 1'b1;
               mul_res  <= m_prod;
            end
         end
         if (mul_valid) begin
            m_prod <= mul_op_a * mul_op_b;
            m_cnt  <= LAT;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int unsigned i, input logic v,
                          input logic [FE_W-1:0] a, input logic [FE_W-1:0] b);
      req_valid[i]               = v;
      req_op_a[i*FE_W +: FE_W]   = a;
      req_op_b[i*FE_W +: FE_W]   = b;
   endtask

   task automatic push_exp(input int unsigned i, input logic [FE_W-1:0] a,
                           input logic [FE_W-1:0] b);
      exp_t e;
      e.id  = i;
      e.res = a * b;
      sbq.push_back(e);
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      req_valid = '0;
      step();
      step();
      rst = 1'b1;
      sbq.delete();
   endtask

   // Steps until a req_done pulse (bounded); reports mul_valid pulses seen.
   task automatic wait_done(output logic [NREQ-1:0] d, output int nv, output bit to);
      to = 1'b1;
      d  = '0;
      nv = 0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (mul_valid === 1'b1) nv++;
         if (req_done !== '0) begin
            d  = req_done;
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({busy, mul_valid, req_done} !== '0) begin
         bad++;
         $display("FAIL reset_ctrl got busy=%0b mul_valid=%0b req_done=%0b exp 0", busy, mul_valid, req_done);
      end
      total++;
      if ((mul_op_a !== '0) || (mul_op_b !== '0) || (req_res !== '0)) begin
         bad++;
         $display("FAIL reset_data got a=%0h b=%0h res=%0h exp 0", mul_op_a, mul_op_b, req_res);
      end
      total++;
      if ((grant_id !== '0) || (mul_count !== '0) || (err_stray !== 1'b0)) begin
         bad++;
         $display("FAIL reset_flags got gid=%0d cnt=%0d err=%0b exp 0", grant_id, mul_count, err_stray);
      end
   endtask

   task automatic test_single();
      exp_t e;
      bit   found;
      set_req(0, 1'b1, 2, 3);
      push_exp(0, 2, 3);
      step();
      total++;
      if (mul_valid !== 1'b1) begin
         bad++;
         $display("FAIL single_issue_latency got mul_valid=%0b exp 1", mul_valid);
      end
      found = 1'b0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (mul_done === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL single_mul_done_timeout got none exp pulse");
      end
      total++;
      if (req_done !== 3'b000) begin
         bad++;
         $display("FAIL single_early_done got %b exp 000", req_done);
      end
      step();
      e = sbq.pop_front();
      total++;
      if (req_done !== 3'b001) begin
         bad++;
         $display("FAIL single_done got %b exp 001", req_done);
      end
      total++;
      if (req_res !== e.res) begin
         bad++;
         $display("FAIL single_res got %0h exp %0h", req_res, e.res);
      end
      req_valid = '0;
      total++;
      if (mul_count !== CNT_W'(1)) begin
         bad++;
         $display("FAIL single_count got %0d exp 1", mul_count);
      end
   endtask

   task automatic test_contention();
      logic [NREQ-1:0] d;
      int              nv;
      bit              to;
      exp_t            e;
      do_reset();
      for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 2, i + 3);
      for (int t = 0; t < 6; t++) push_exp(t % NREQ, (t % NREQ) + 2, (t % NREQ) + 3);
      for (int t = 0; t < 6; t++) begin
         wait_done(d, nv, to);
         total++;
         if (to) begin
            bad++;
            $display("FAIL contention_timeout txn=%0d got none exp done", t);
         end else begin
            e = sbq.pop_front();
            total++;
            if (d !== NREQ'(1 << e.id)) begin
               bad++;
               $display("FAIL contention_done txn=%0d got %b exp id %0d", t, d, e.id);
            end
            total++;
            if (req_res !== e.res) begin
               bad++;
               $display("FAIL contention_res txn=%0d got %0d exp %0d", t, req_res, e.res);
            end
            total++;
            if (nv != 1) begin
               bad++;
               $display("FAIL contention_issue_pulses txn=%0d got %0d exp 1", t, nv);
            end
         end
         if (t == 5) req_valid = '0;
      end
      req_valid = '0;
   endtask

   task automatic test_rerequest();
      logic [NREQ-1:0] d;
      int              nv;
      bit              to;
      exp_t            e;
      do_reset();
      set_req(1, 1'b1, 4, 5);
      push_exp(1, 4, 5);
      set_req(2, 1'b1, 6, 7);
      push_exp(2, 6, 7);
      for (int t = 0; t < 3; t++) begin
         wait_done(d, nv, to);
         total++;
         if (to) begin
            bad++;
            $display("FAIL rereq_timeout txn=%0d got none exp done", t);
         end else begin
            e = sbq.pop_front();
            total++;
            if ((d !== NREQ'(1 << e.id)) || (req_res !== e.res)) begin
               bad++;
               $display("FAIL rereq_order txn=%0d got done=%b res=%0d exp id=%0d res=%0d", t, d, req_res, e.id, e.res);
            end
         end
         if (t == 0) begin
            set_req(1, 1'b1, 5, 7);
            push_exp(1, 5, 7);
         end else if (t == 1) begin
            req_valid[2] = 1'b0;
         end else begin
            req_valid[1] = 1'b0;
         end
      end
      req_valid = '0;
   endtask

   task automatic test_stray();
      logic [NREQ-1:0] d;
      int              nv;
      bit              to;
      exp_t            e;
      total++;
      if (err_stray !== 1'b0) begin
         bad++;
         $display("FAIL stray_pre got %0b exp 0", err_stray);
      end
      stray_go = 1'b1;
      step();
      stray_go = 1'b0;
      step();
      total++;
      if ((err_stray !== 1'b1) || (busy !== 1'b0) || (req_done !== '0)) begin
         bad++;
         $display("FAIL stray_flag got err=%0b busy=%0b done=%b exp 1 0 000", err_stray, busy, req_done);
      end
      step();
      step();
      total++;
      if ((err_stray !== 1'b1) || (busy !== 1'b0)) begin
         bad++;
         $display("FAIL stray_sticky got err=%0b busy=%0b exp 1 0", err_stray, busy);
      end
      set_req(0, 1'b1, 3, 3);
      push_exp(0, 3, 3);
      wait_done(d, nv, to);
      req_valid = '0;
      total++;
      if (to) begin
         bad++;
         $display("FAIL stray_after_timeout got none exp done");
      end else begin
         e = sbq.pop_front();
         total++;
         if ((d !== 3'b001) || (req_res !== e.res)) begin
            bad++;
            $display("FAIL stray_after got done=%b res=%0d exp 001 res=%0d", d, req_res, e.res);
         end
      end
   endtask

   task automatic test_reset_wait();
      logic [NREQ-1:0] d;
      int              nv;
      bit              to;
      exp_t            e;
      set_req(2, 1'b1, 2, 5);
      step();
      step();
      rst       = 1'b0;
      req_valid = '0;
      step();
      rst = 1'b1;
      total++;
      if ({busy, mul_valid, req_done} !== '0) begin
         bad++;
         $display("FAIL rstwait_ctrl got busy=%0b mv=%0b done=%b exp 0", busy, mul_valid, req_done);
      end
      total++;
      if ((mul_count !== '0) || (grant_id !== '0) || (err_stray !== 1'b0)) begin
         bad++;
         $display("FAIL rstwait_flags got cnt=%0d gid=%0d err=%0b exp 0", mul_count, grant_id, err_stray);
      end
      sbq.delete();
      for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 2, i + 3);
      push_exp(0, 2, 3);
      wait_done(d, nv, to);
      req_valid = '0;
      total++;
      if (to) begin
         bad++;
         $display("FAIL rstwait_timeout got none exp done");
      end else begin
         e = sbq.pop_front();
         total++;
         if ((d !== 3'b001) || (grant_id !== 2'd0) || (req_res !== e.res)) begin
            bad++;
            $display("FAIL rstwait_first got done=%b gid=%0d res=%0d exp 001 0 %0d", d, grant_id, req_res, e.res);
         end
         total++;
         if (mul_count !== CNT_W'(1)) begin
            bad++;
            $display("FAIL rstwait_count got %0d exp 1", mul_count);
         end
      end
   endtask

   task automatic test_wrap();
      logic [NREQ-1:0]  d;
      int               nv;
      bit               to;
      exp_t             e;
      logic [CNT_W-1:0] exp_cnt;
      do_reset();
      exp_cnt = '0;
      for (int n = 1; n <= 16; n++) begin
         set_req(0, 1'b1, n, n + 1);
         push_exp(0, n, n + 1);
         exp_cnt = exp_cnt + CNT_W'(1);
         wait_done(d, nv, to);
         req_valid = '0;
         total++;
         if (to) begin
            bad++;
            $display("FAIL wrap_timeout n=%0d got none exp done", n);
         end else begin
            e = sbq.pop_front();
            total++;
            if (req_res !== e.res) begin
               bad++;
               $display("FAIL wrap_res n=%0d got %0d exp %0d", n, req_res, e.res);
            end
            total++;
            if (mul_count !== exp_cnt) begin
               bad++;
               $display("FAIL wrap_count n=%0d got %0d exp %0d", n, mul_count, exp_cnt);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_rerequest();
      test_stray();
      test_reset_wait();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
